skid_buffer: RTL and testbench

SKID_BUFFER -- requirements
Module: skid_buffer

---
 rtl/skid_buffer_pkg.sv | 20 ++
 rtl/xfer_counter.sv | 34 +++
 rtl/skid_buffer.sv | 108 ++++++++++
 tb/tb_skid_buffer.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/skid_buffer_pkg.sv
// +--------------------------------------------------------------------+
// | skid_buffer_pkg                                                    |
// | Shared state encoding and counter width for the skid buffer.       |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

package skid_buffer_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } state_t;

    localparam int COUNT_WIDTH = 32;

endpackage : skid_buffer_pkg

`default_nettype wire

// File: rtl/xfer_counter.sv
// +--------------------------------------------------------------------+
// | xfer_counter                                                       |
// | Free-running wrap-around event counter with asynchronous reset.    |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module xfer_counter
    import skid_buffer_pkg::*;
#(
    parameter int WIDTH = COUNT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] r_count;

    // Natural modulo-2^WIDTH wrap on overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (inc) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign count = r_count;

endmodule : xfer_counter

`default_nettype wire

// File: rtl/skid_buffer.sv
// +--------------------------------------------------------------------+
// | skid_buffer                                                        |
// | Two-entry valid/ready register slice with fully registered         |
// | outputs. Optional transfer counter: define SKID_BUFFER_STATS_EN.   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module skid_buffer
    import skid_buffer_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_data
`ifdef SKID_BUFFER_STATS_EN
    ,
    output logic [COUNT_WIDTH-1:0] xfer_count
`endif
);

    state_t           r_state;
    logic [WIDTH-1:0] r_main;
    logic [WIDTH-1:0] r_skid;
    logic             r_out_valid;
    logic             r_in_ready;
    logic             w_in_xfer;
    logic             w_out_xfer;

    assign w_in_xfer  = in_valid  & r_in_ready;
    assign w_out_xfer = r_out_valid & out_ready;

    // Handshake flags are kept as registers alongside the state so that
    // in_ready never depends combinationally on out_ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= EMPTY;
            r_main      <= '0;
            r_skid      <= '0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_in_xfer) begin
                        r_main      <= in_data;
                        r_state     <= FULL;
                        r_out_valid <= 1'b1;
                    end
                end
                FULL: begin
                    case ({w_in_xfer, w_out_xfer})
                        2'b11: begin
                            r_main <= in_data;
                        end
                        2'b01: begin
                            r_state     <= EMPTY;
                            r_out_valid <= 1'b0;
                        end
                        2'b10: begin
                            r_skid     <= in_data;
                            r_state    <= SKID;
                            r_in_ready <= 1'b0;
                        end
                        default: begin
                        end
                    endcase
                end
                SKID: begin
                    if (w_out_xfer) begin
                        r_main     <= r_skid;
                        r_state    <= FULL;
                        r_in_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= EMPTY;
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                end
            endcase
        end
    end

    assign out_valid = r_out_valid;
    assign in_ready  = r_in_ready;
    assign out_data  = r_main;

`ifdef SKID_BUFFER_STATS_EN
    xfer_counter #(
        .WIDTH (COUNT_WIDTH)
    ) u_xfer_counter (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_out_xfer),
        .count (xfer_count)
    );
`endif

endmodule : skid_buffer

`default_nettype wire

// File: tb/tb_skid_buffer.sv
// +--------------------------------------------------------------------+
// | tb_skid_buffer                                                     |
// | Scoreboard bench for skid_buffer (SKID_BUFFER_STATS_EN optional).  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_skid_buffer;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
`ifdef SKID_BUFFER_STATS_EN
    logic [31:0]      xfer_count;
`endif

    int               checks;
    int               errors;
    logic             last_acc;
    logic [WIDTH-1:0] q_exp[$];
    logic [WIDTH-1:0] q_obs[$];

    skid_buffer #(
        .WIDTH (WIDTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data)
`ifdef SKID_BUFFER_STATS_EN
        ,
        .xfer_count (xfer_count)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One clock: transfers are judged mid-cycle, inputs may change at +1.
    task automatic tick();
        @(negedge clk);
        last_acc = 1'b0;
        if (!rst) begin
            if (in_valid && in_ready) begin
                q_exp.push_back(in_data);
                last_acc = 1'b1;
            end
            if (out_valid && out_ready) q_obs.push_back(out_data);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        rst       = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        q_exp.delete();
        q_obs.delete();
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'hC3;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_outputs: valid=%b ready=%b data=%h, required 0 1 00",
                     out_valid, in_ready, out_data);
        end
`ifdef SKID_BUFFER_STATS_EN
        checks++;
        if (xfer_count !== 32'd0) begin
            errors++;
            $display("FAIL reset_count: got %0d, required 0", xfer_count);
        end
`endif
        in_data = 8'h3C;
        rst     = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h3C) begin
            errors++;
            $display("FAIL first_after_reset: valid=%b data=%h, required 1 3c",
                     out_valid, out_data);
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_streaming();
        do_reset();
        out_ready = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            in_valid = 1'b1;
            in_data  = WIDTH'(i);
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("FAIL stream_in_ready: word %0d got %b, required 1", i, in_ready);
            end
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_data !== WIDTH'(i)) begin
                errors++;
                $display("FAIL stream_latency: word %0d valid=%b data=%h, required 1 %h",
                         i, out_valid, out_data, WIDTH'(i));
            end
        end
        in_valid = 1'b0;
        tick();
        checks++;
        if (q_obs.size() != 16 || q_exp.size() != 16) begin
            errors++;
            $display("FAIL stream_count: got %0d words, required 16", q_obs.size());
        end
        for (int i = 0; i < q_obs.size() && i < 16; i++) begin
            checks++;
            if (q_obs[i] !== WIDTH'(i + 1)) begin
                errors++;
                $display("FAIL stream_order: idx %0d got %h, required %h", i, q_obs[i], WIDTH'(i + 1));
            end
        end
`ifdef SKID_BUFFER_STATS_EN
        checks++;
        if (xfer_count !== 32'd16) begin
            errors++;
            $display("FAIL stream_xfer_count: got %0d, required 16", xfer_count);
        end
`endif
    endtask

    task automatic test_backpressure();
        logic [WIDTH-1:0] exp_words[3];
        exp_words[0] = 8'hA1;
        exp_words[1] = 8'hA2;
        exp_words[2] = 8'hA3;
        do_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'hA1;
        tick();
        in_data = 8'hA2;
        tick();
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_skid_flags: in_ready=%b out_valid=%b, required 0 1", in_ready, out_valid);
        end
        in_data = 8'hA3;
        // Stall in SKID: head word must not move, A3 must stay held off.
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (out_data !== 8'hA1 || out_valid !== 1'b1 || in_ready !== 1'b0 || last_acc) begin
                errors++;
                $display("FAIL stall_stable: cycle %0d data=%h valid=%b ready=%b acc=%b, required a1 1 0 0",
                         i, out_data, out_valid, in_ready, last_acc);
            end
        end
        out_ready = 1'b1;
        for (int i = 0; i < 20 && q_obs.size() < 3; i++) begin
            tick();
            if (last_acc) in_valid = 1'b0;
        end
        in_valid = 1'b0;
        checks++;
        if (q_obs.size() != 3) begin
            errors++;
            $display("FAIL bp_count: got %0d words, required 3", q_obs.size());
        end
        for (int i = 0; i < q_obs.size() && i < 3; i++) begin
            checks++;
            if (q_obs[i] !== exp_words[i]) begin
                errors++;
                $display("FAIL bp_order: idx %0d got %h, required %h", i, q_obs[i], exp_words[i]);
            end
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'hB1;
        tick();
        in_data = 8'hB2;
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL midrst_setup: valid=%b ready=%b, required 1 0", out_valid, in_ready);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 8'h00) begin
            errors++;
            $display("FAIL midrst_async: valid=%b ready=%b data=%h, required 0 1 00",
                     out_valid, in_ready, out_data);
        end
        rst = 1'b0;
        q_exp.delete();
        q_obs.delete();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'h55;
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        checks++;
        if (q_obs.size() != 1) begin
            errors++;
            $display("FAIL midrst_count: got %0d words, required 1", q_obs.size());
        end else begin
            checks++;
            if (q_obs[0] !== 8'h55) begin
                errors++;
                $display("FAIL midrst_word: got %h, required 55", q_obs[0]);
            end
        end
    endtask

    task automatic test_random();
        int sent;
        int cyc;
        do_reset();
        sent = 0;
        cyc  = 0;
        while (sent < 1000 && cyc < 20000) begin
            in_valid  = ($urandom_range(0, 1) == 1);
            in_data   = WIDTH'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
            if (last_acc) sent++;
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 10 && q_obs.size() < q_exp.size(); i++) tick();
        checks++;
        if (q_exp.size() != 1000 || q_obs.size() != 1000) begin
            errors++;
            $display("FAIL rand_count: sent %0d received %0d, required 1000 each",
                     q_exp.size(), q_obs.size());
        end
        for (int i = 0; i < q_obs.size() && i < q_exp.size(); i++) begin
            checks++;
            if (q_obs[i] !== q_exp[i]) begin
                errors++;
                $display("FAIL rand_data: idx %0d got %h, required %h", i, q_obs[i], q_exp[i]);
            end
        end
`ifdef SKID_BUFFER_STATS_EN
        checks++;
        if (xfer_count !== 32'd1000) begin
            errors++;
            $display("FAIL rand_xfer_count: got %0d, required 1000", xfer_count);
        end
`endif
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        last_acc  = 1'b0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        test_reset();
        test_streaming();
        test_backpressure();
        test_mid_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_skid_buffer

`default_nettype wire
